// File: rtl/boreal_pkg.sv
// rtl/boreal_pkg.sv - shared constants and FSM encoding for the boreal biquad config controller
package boreal_pkg;

  localparam int NUM_COEF = 5;

  localparam logic [2:0] COEF_B0 = 3'd0;
  localparam logic [2:0] COEF_B1 = 3'd1;
  localparam logic [2:0] COEF_B2 = 3'd2;
  localparam logic [2:0] COEF_A1 = 3'd3;
  localparam logic [2:0] COEF_A2 = 3'd4;

  localparam logic [15:0] Q15_ONE = 16'h7FFF;

  localparam int CTRL_COMMIT_BIT  = 0;
  localparam int CTRL_CLEAR_BIT   = 1;
  localparam int STAT_OVERRUN_BIT = 0;
  localparam int STAT_DROP_BIT    = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

endpackage

// File: rtl/boreal_coef_bank.sv
// rtl/boreal_coef_bank.sv - shadow coefficient register file, one write port, one async read port
module boreal_coef_bank
  import boreal_pkg::*;
#(
  parameter int NUM_SECT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [4:0]  wr_sect,
  input  logic [2:0]  wr_coef,
  input  logic [15:0] wr_data,
  input  logic [4:0]  rd_sect,
  input  logic [2:0]  rd_coef,
  output logic [15:0] rd_data
);

  localparam int DEPTH = NUM_SECT * NUM_COEF;
  localparam int IW    = $clog2(DEPTH);

  logic [15:0] mem_q [DEPTH];
  logic [15:0] mem_d [DEPTH];
  int          wr_lin;
  int          rd_lin;

  always_comb begin
    mem_d  = mem_q;
    wr_lin = int'(wr_sect) * NUM_COEF + int'(wr_coef);
    rd_lin = int'(rd_sect) * NUM_COEF + int'(rd_coef);
    if (wr_en && (wr_lin < DEPTH)) begin
      mem_d[IW'(wr_lin)] = wr_data;
    end
    rd_data = (rd_lin < DEPTH) ? mem_q[IW'(rd_lin)] : 16'h0000;
  end

  // Reset leaves each section as a unity-gain passthrough (b0 = 1.0, rest 0).
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        mem_q[i] <= ((i % NUM_COEF) == int'(COEF_B0)) ? Q15_ONE : 16'h0000;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

endmodule

// File: rtl/boreal_biquad_cfg_ctrl.sv
// rtl/boreal_biquad_cfg_ctrl.sv - commit FSM, sample gate and hold buffer feeding the biquad cascade
module boreal_biquad_cfg_ctrl
  import boreal_pkg::*;
#(
  parameter int          NUM_SECT  = 4,
  parameter int          PIPE_LAT  = 4,
  parameter logic [7:0]  CTRL_ADDR = 8'hFF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [7:0]          cfg_addr,
  input  logic [15:0]         cfg_wdata,
  input  logic                s_valid,
  input  logic signed [23:0]  s_data,
  output logic                m_valid,
  output logic signed [23:0]  m_data,
  output logic [2:0]          bq_reg_addr,
  output logic [15:0]         bq_reg_din,
  output logic [NUM_SECT-1:0] bq_reg_we,
  output logic                busy,
  output logic                commit_done,
  output logic [1:0]          status
);

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [4:0]         ld_sect_q, ld_sect_d;
  logic [2:0]         ld_coef_q, ld_coef_d;
  logic               hold_v_q, hold_v_d;
  logic signed [23:0] hold_data_q, hold_data_d;
  logic               m_valid_q, m_valid_d;
  logic signed [23:0] m_data_q, m_data_d;
  logic               commit_done_q, commit_done_d;
  logic [1:0]         status_q, status_d;

  logic        ctrl_hit, shadow_hit, shadow_we, commit, last_load, gate_closed;
  logic [1:0]  status_set;
  logic [15:0] rd_data;

  boreal_coef_bank #(.NUM_SECT(NUM_SECT)) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (shadow_we),
    .wr_sect (cfg_addr[7:3]),
    .wr_coef (cfg_addr[2:0]),
    .wr_data (cfg_wdata),
    .rd_sect (ld_sect_q),
    .rd_coef (ld_coef_q),
    .rd_data (rd_data)
  );

  always_comb begin
    ctrl_hit    = cfg_we && (cfg_addr == CTRL_ADDR);
    shadow_hit  = cfg_we && !ctrl_hit && (int'(cfg_addr[7:3]) < NUM_SECT) && (cfg_addr[2:0] <= COEF_A2);
    shadow_we   = shadow_hit && (state_q != ST_LOAD);
    commit      = ctrl_hit && cfg_wdata[CTRL_COMMIT_BIT] && (state_q == ST_IDLE);
    last_load   = (state_q == ST_LOAD) && (int'(ld_sect_q) == NUM_SECT - 1) && (ld_coef_q == COEF_A2);
    // The commit cycle already counts as closed so nothing reaches section 0 during DRAIN.
    gate_closed = (state_q != ST_IDLE) || commit;

    state_d       = state_q;
    cnt_d         = cnt_q;
    ld_sect_d     = ld_sect_q;
    ld_coef_d     = ld_coef_q;
    hold_v_d      = hold_v_q;
    hold_data_d   = hold_data_q;
    m_valid_d     = 1'b0;
    m_data_d      = m_data_q;
    commit_done_d = 1'b0;
    status_set    = 2'b00;

    if (s_valid) begin
      if (!gate_closed) begin
        m_valid_d = 1'b1;
        m_data_d  = s_data;
      end else if (!hold_v_q) begin
        hold_v_d    = 1'b1;
        hold_data_d = s_data;
      end else begin
        status_set[STAT_OVERRUN_BIT] = 1'b1;
      end
    end
    if (shadow_hit && (state_q == ST_LOAD)) begin
      status_set[STAT_DROP_BIT] = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (commit) begin
          state_d = ST_DRAIN;
          cnt_d   = 8'(PIPE_LAT);
        end
      end
      ST_DRAIN: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d   = ST_LOAD;
          ld_sect_d = 5'd0;
          ld_coef_d = COEF_B0;
        end
      end
      ST_LOAD: begin
        if (last_load) begin
          state_d       = ST_IDLE;
          commit_done_d = 1'b1;
          // Replay uses the _d view so a sample captured on this very cycle is not stranded.
          if (hold_v_d) begin
            m_valid_d = 1'b1;
            m_data_d  = hold_data_d;
            hold_v_d  = 1'b0;
          end
        end else if (ld_coef_q == COEF_A2) begin
          ld_coef_d = COEF_B0;
          ld_sect_d = ld_sect_q + 5'd1;
        end else begin
          ld_coef_d = ld_coef_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    status_d = ((ctrl_hit && cfg_wdata[CTRL_CLEAR_BIT]) ? 2'b00 : status_q) | status_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 8'd0;
      ld_sect_q     <= 5'd0;
      ld_coef_q     <= 3'd0;
      hold_v_q      <= 1'b0;
      hold_data_q   <= 24'sd0;
      m_valid_q     <= 1'b0;
      m_data_q      <= 24'sd0;
      commit_done_q <= 1'b0;
      status_q      <= 2'b00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ld_sect_q     <= ld_sect_d;
      ld_coef_q     <= ld_coef_d;
      hold_v_q      <= hold_v_d;
      hold_data_q   <= hold_data_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      commit_done_q <= commit_done_d;
      status_q      <= status_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SECT; i++) begin
      bq_reg_we[i] = (state_q == ST_LOAD) && (int'(ld_sect_q) == i);
    end
    bq_reg_addr = (state_q == ST_LOAD) ? ld_coef_q : 3'd0;
    bq_reg_din  = (state_q == ST_LOAD) ? rd_data : 16'h0000;
  end

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign busy        = (state_q != ST_IDLE);
  assign commit_done = commit_done_q;
  assign status      = status_q;

endmodule

// File: tb/tb_boreal_biquad_cfg_ctrl.sv
// tb/tb_boreal_biquad_cfg_ctrl.sv - randomized scoreboard bench for boreal_biquad_cfg_ctrl
module tb_boreal_biquad_cfg_ctrl;

  localparam int NS = 4;
  localparam int PL = 4;
  localparam int LAST_PH = PL + 5 * NS - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cfg_we = 1'b0;
  logic [7:0]         cfg_addr = 8'h00;
  logic [15:0]        cfg_wdata = 16'h0000;
  logic               s_valid = 1'b0;
  logic signed [23:0] s_data = 24'sd0;
  logic               m_valid;
  logic signed [23:0] m_data;
  logic [2:0]         bq_reg_addr;
  logic [15:0]        bq_reg_din;
  logic [NS-1:0]      bq_reg_we;
  logic               busy;
  logic               commit_done;
  logic [1:0]         status;

  boreal_biquad_cfg_ctrl #(.NUM_SECT(NS), .PIPE_LAT(PL), .CTRL_ADDR(8'hFF)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .bq_reg_addr (bq_reg_addr),
    .bq_reg_din  (bq_reg_din),
    .bq_reg_we   (bq_reg_we),
    .busy        (busy),
    .commit_done (commit_done),
    .status      (status)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [23:0] data;
  } m_exp_t;

  typedef struct {
    int          cyc;
    logic [NS-1:0] we;
    logic [2:0]  addr;
    logic [15:0] din;
  } bq_exp_t;

  m_exp_t  m_q[$];
  bq_exp_t bq_q[$];
  int      done_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: shadow contents, sticky status, hold slot and the
  // number of busy cycles elapsed since the commit (-1 when idle).
  logic [15:0] shadow [NS][5];
  logic [1:0]  st_exp;
  logic        hold_v;
  logic [23:0] hold_d;
  int          ph;
  bit          post_rst;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++)
      for (int c = 0; c < 5; c++)
        shadow[s][c] = (c == 0) ? 16'h7FFF : 16'h0000;
    st_exp   = 2'b00;
    hold_v   = 1'b0;
    hold_d   = 24'h0;
    ph       = -1;
  endtask

  task automatic step(input logic r, input logic we, input logic [7:0] a,
                      input logic [15:0] wd, input logic sv, input logic [23:0] sd);
    logic [1:0] set;
    logic       clr, cmt, last;
    bq_exp_t    be;
    @(posedge clk);
    #1;
    check("busy", {31'h0, busy}, {31'h0, (ph >= 0)});
    check("status", {30'h0, status}, {30'h0, st_exp});
    if (post_rst) begin
      check("rst_m_valid", {31'h0, m_valid}, 32'h0);
      check("rst_bq_we", 32'(bq_reg_we), 32'h0);
      check("rst_commit_done", {31'h0, commit_done}, 32'h0);
      post_rst = 1'b0;
    end
    rst = r; cfg_we = we; cfg_addr = a; cfg_wdata = wd; s_valid = sv; s_data = sd;

    if (ph >= PL) begin
      int k;
      k = ph - PL;
      be.cyc  = cyc;
      be.we   = '0;
      be.we[k / 5] = 1'b1;
      be.addr = 3'(k % 5);
      be.din  = shadow[k / 5][k % 5];
      bq_q.push_back(be);
    end

    if (r) begin
      model_reset();
      post_rst = 1'b1;
      return;
    end

    set = 2'b00; clr = 1'b0; cmt = 1'b0;
    if (we) begin
      if (a == 8'hFF) begin
        clr = wd[1];
        cmt = wd[0] && (ph < 0);
      end else if ((int'(a[7:3]) < NS) && (a[2:0] < 3'd5)) begin
        if (ph >= PL) set[1] = 1'b1;
        else shadow[a[7:3]][a[2:0]] = wd;
      end
    end

    if (sv) begin
      if (ph < 0 && !cmt) m_q.push_back('{cyc + 1, sd});
      else if (!hold_v) begin hold_v = 1'b1; hold_d = sd; end
      else set[0] = 1'b1;
    end

    last = (ph == LAST_PH);
    if (last) begin
      if (hold_v) begin
        m_q.push_back('{cyc + 1, hold_d});
        hold_v = 1'b0;
      end
      done_q.push_back(cyc + 1);
    end

    st_exp = (clr ? 2'b00 : st_exp) | set;
    if (cmt) ph = 0;
    else if (last) ph = -1;
    else if (ph >= 0) ph++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 16'h0, 0, 24'h0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    step(0, 1, a, d, 0, 24'h0);
  endtask

  always @(negedge clk) begin
    m_exp_t  me;
    bq_exp_t be;
    int      dc;
    if (m_valid === 1'b1) begin
      if (m_q.size() == 0) check("m_valid_unexpected", 32'h1, 32'h0);
      else begin
        me = m_q.pop_front();
        check("m_cycle", cyc, me.cyc);
        check("m_data", {8'h00, m_data}, {8'h00, me.data});
      end
    end
    if ((bq_reg_we !== '0) && (bq_reg_we !== 'x)) begin
      if (bq_q.size() == 0) check("bq_we_unexpected", 32'(bq_reg_we), 32'h0);
      else begin
        be = bq_q.pop_front();
        check("bq_cycle", cyc, be.cyc);
        check("bq_we", 32'(bq_reg_we), 32'(be.we));
        check("bq_addr", {29'h0, bq_reg_addr}, {29'h0, be.addr});
        check("bq_din", {16'h0, bq_reg_din}, {16'h0, be.din});
      end
    end
    if (commit_done === 1'b1) begin
      if (done_q.size() == 0) check("commit_done_unexpected", 32'h1, 32'h0);
      else begin
        dc = done_q.pop_front();
        check("commit_done_cycle", cyc, dc);
      end
    end
  end

  initial begin
    int guard;
    model_reset();
    post_rst = 1'b1;
    step(1, 0, 8'h00, 16'h0, 0, 24'h0);
    step(1, 0, 8'h00, 16'h0, 0, 24'h0);
    step(0, 0, 8'h00, 16'h0, 1, 24'h000100);
    idle(3);

    wr({5'd1, 3'd3}, 16'hC000);
    wr(8'hFF, 16'h0001);
    for (int i = 0; i < 28; i++) begin
      if (ph == PL + 7) wr({5'd0, 3'd1}, 16'h1234);
      else step(0, 0, 8'h00, 16'h0, (ph == PL + 2) || (ph == PL + 5), 24'($urandom));
    end
    wr(8'hFF, 16'h0002);
    idle(2);

    wr(8'hFF, 16'h0001);
    guard = 0;
    while (ph != PL + 5 && guard < 100) begin
      idle(1);
      guard++;
    end
    check("reach_load5", {31'h0, (ph == PL + 5)}, 32'h1);
    step(1, 0, 8'h00, 16'h0, 0, 24'h0);
    idle(2);

    wr({5'd7, 3'd0}, 16'hAAAA);
    wr({5'd2, 3'd6}, 16'hBBBB);
    wr({5'd2, 3'd1}, 16'h0F0F);
    wr(8'hFF, 16'h0001);
    idle(1);
    wr(8'hFF, 16'h0001);
    idle(30);

    for (int i = 0; i < 3000; i++) begin
      int          sel;
      logic        r, we, sv;
      logic [7:0]  a;
      logic [15:0] d;
      r   = ($urandom_range(0, 999) == 0);
      sel = $urandom_range(0, 99);
      sv  = $urandom_range(0, 1);
      we  = 1'b0; a = 8'h00; d = 16'($urandom);
      if (sel < 3) begin we = 1'b1; a = 8'hFF; d[0] = 1'b1; end
      else if (sel < 6) begin we = 1'b1; a = 8'hFF; d = 16'h0002; end
      else if (sel < 20) begin we = 1'b1; a = {5'($urandom_range(0, 7)), 3'($urandom_range(0, 7))}; end
      step(r, we, a, d, sv, 24'($urandom));
    end

    idle(40);
    check("m_queue_empty", m_q.size(), 0);
    check("bq_queue_empty", bq_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
